alu_share_arbiter: RTL
======================

# alu_share_arbiter

Arbitrates a single combinational 32-bit ALU between two requesters: the execute stage (port 0) and the branch/address-compare unit (port 1). Each requester issues operands and a 3-bit operation over a valid/ready handshake. The block drives the shared ALU from registered operands and returns the result plus four status flags on a per-port response handshake. It sits between the pipeline control logic and the ALU instance, so the ALU never sees two operations in one cycle.

## Interface
- WIDTH, 32, operand/result width
- CTRL_W, 3, ALU operation code width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present on port N
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_ctrl / req1_ctrl  in  CTRL_W  operation: 000 add, 001 sub, 010 and, 011 or, 101 set-less-than (sign of A−B)
- rsp0_valid / rsp1_valid  out  1  response pending for port N
- rsp0_ready / rsp1_ready  in  1  requester consumes response
- rsp_res  out  WIDTH  registered result (shared by both ports)
- rsp_flags  out  4  {carry, overflow, zero, negative}, registered
- rsp_err  out  1  operation code was illegal
- alu_a, alu_b  out  WIDTH  to ALU
- alu_ctrl  out  CTRL_W  to ALU
- alu_res  in  WIDTH  from ALU
- alu_flags  in  4  {carry, overflow, zero, negative} from ALU
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE: the arbiter picks a winner among the asserted reqN_valid and raises only that reqN_ready. On valid&&ready, latch a, b, ctrl and the port id, then go to EXEC. With no valid request, stay in IDLE with both ready low.
- EXEC: alu_a/alu_b/alu_ctrl are driven from the latched registers. At the clock edge, capture alu_res, alu_flags and err into the response registers, then go to RESP.
- RESP: hold rspN_valid for the latched port. On rspN_ready, go to IDLE. Both ready outputs stay low in EXEC and RESP.
- Illegal ctrl (100, 110, 111): the code is still forwarded to the ALU, but rsp_res is forced to 0 and rsp_err=1. Flags are captured from the ALU unchanged.
- alu_* outputs in IDLE: hold the last latched values, no toggling.
- The block does no arithmetic of its own. The result width equals WIDTH, and the carry-out is carried only in the flags.
- Reset values: all ready/valid outputs 0; busy 0; rsp_res 0; rsp_flags 0; rsp_err 0; alu_a, alu_b, alu_ctrl 0; last-grant register = port 1, so port 0 wins first.
- rst asserted in any state: return to IDLE next edge. Any in-flight operation is dropped and no response is issued.
- A request that is withdrawn (valid low) before a handshake is simply not granted. The arbiter is not sticky in IDLE.

## Timing
- Handshake at edge T → EXEC during cycle T+1 → rspN_valid high from cycle T+2.
- Minimum occupancy is 3 cycles per operation. Maximum throughput is one op per 3 cycles when rsp_ready is held high.
- A response held off by rspN_ready=0 blocks both ports. rsp_res, rsp_flags and rsp_err stay stable while rspN_valid is high.
- Both valid in IDLE simultaneously: resolved per Configuration, in the same cycle.

## Configuration
- ALU_ARB_RR_EN defined: round-robin. The port not granted last wins when both are valid. last_grant updates on each handshake.
- ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins a tie. The last_grant register is not built.

## Structure
- The shared package holds:
  - The ALU op-code constants (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101).
  - The flag bit indices.
  - The FSM state enum.
  - A legal-op check function.
- One sub-module: alu_arb_pick, the 2-way combinational grant logic (fixed or round-robin). Inputs are the valid bits and last_grant; outputs are one-hot grants.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Add: port0 add a=5, b=7, rsp0_ready=1 → rsp0_valid at T+2; rsp_res=12; flags 0000; rsp_err=0; rsp1_valid stays 0.
- Subtract to zero: port1 sub a=3, b=3 → rsp_res=0; zero=1; carry=1; overflow=0; negative=0.
- Signed overflow: port0 add a=0x7FFFFFFF, b=1 → rsp_res=0x80000000; overflow=1; negative=1. Set-less-than: ctrl 101, a=2, b=5 → rsp_res=1.
- Contention: both ports valid continuously with add ops.
  - With ALU_ARB_RR_EN: grants alternate 0,1,0,1.
  - Without it: port 0 is granted every time and port 1 never.
- Backpressure and illegal op: ctrl 111 with rsp0_ready=0 for 4 cycles.
  - rsp0_valid is held, with rsp_res=0 and rsp_err=1 stable.
  - Both req ready outputs stay 0.
  - IDLE is reached one cycle after rsp0_ready=1.
- Reset mid-operation: assert rst during EXEC.
  - Next cycle: busy=0 and all outputs at reset values.
  - No rspN_valid pulse ever appears for the dropped op.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: shared op codes, flag indices, FSM states and op-legality check
package alu_share_arbiter_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_e;
    function automatic logic is_legal_op(input logic [2:0] op);
        return op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
    endfunction
endpackage

// File: rtl/alu_share_arbiter_pick.sv
// alu_arb_pick: 2-way one-hot grant; round-robin with ALU_ARB_RR_EN, else port 0 wins ties
module alu_arb_pick (
    input  logic [1:0] valid_i,
`ifdef ALU_ARB_RR_EN
    input  logic       last_grant_i,
`endif
    output logic [1:0] grant_o
);
    always_comb begin
`ifdef ALU_ARB_RR_EN
        grant_o = &valid_i ? (last_grant_i ? 2'b01 : 2'b10) : valid_i;
`else
        grant_o = valid_i[0] ? 2'b01 : valid_i;
`endif
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters (IDLE/EXEC/RESP).
// Tie-break is round-robin when ALU_ARB_RR_EN is defined, fixed priority to port 0 otherwise.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp_res,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_res,
    input  logic [3:0]        alu_flags,
    output logic              busy
);
    state_e state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic port_q, err_q, hs, rsp_take;
    logic [3:0] flags_q;
    logic [1:0] grant;

`ifdef ALU_ARB_RR_EN
    logic last_q;
    alu_arb_pick u_pick (.valid_i({req1_valid, req0_valid}), .last_grant_i(last_q), .grant_o(grant));
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else if (hs) last_q <= grant[1];
    end
`else
    alu_arb_pick u_pick (.valid_i({req1_valid, req0_valid}), .grant_o(grant));
`endif

    assign req0_ready = (state_q == S_IDLE) && grant[0];
    assign req1_ready = (state_q == S_IDLE) && grant[1];
    assign hs         = req0_ready || req1_ready;
    assign rsp_take   = port_q ? rsp1_ready : rsp0_ready;
    assign rsp0_valid = (state_q == S_RESP) && !port_q;
    assign rsp1_valid = (state_q == S_RESP) && port_q;
    assign busy       = state_q != S_IDLE;
    assign rsp_res    = res_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    // The ALU sees only latched operands, so its inputs stay quiet while idle.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;

    always_comb begin
        state_d = state_q == S_IDLE ? (hs ? S_EXEC : S_IDLE) :
                  state_q == S_EXEC ? S_RESP : (rsp_take ? S_IDLE : S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            port_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                a_q    <= grant[1] ? req1_a : req0_a;
                b_q    <= grant[1] ? req1_b : req0_b;
                ctrl_q <= grant[1] ? req1_ctrl : req0_ctrl;
                port_q <= grant[1];
            end
            if (state_q == S_EXEC) begin
                res_q   <= is_legal_op(ctrl_q) ? alu_res : '0;
                flags_q <= alu_flags;
                err_q   <= !is_legal_op(ctrl_q);
            end
        end
    end
endmodule
